// File: rtl/trivium_pkg.sv
// Constants and types shared by the Trivium UART front end (uart_rx_byte, uart_sync, future uart_tx).
package trivium_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 10416;  // 100 MHz core clock, 9600 baud

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Metastability synchronizer for an asynchronous, idle-high serial line.
// Latency SYNC_STAGES cycles; no backpressure. Resets to 1 so a reset never looks like a start bit.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver feeding a one-entry valid/ready byte buffer; rx_valid rises 1 cycle after the stop sample.
// A full, unconsumed buffer drops the new byte and pulses overrun. UART_RX_MAJORITY_EN: 2-of-3 vote per sample.
module uart_rx_byte
  import trivium_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0]    C_BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(UART_DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  // Whole frame shifted one cycle late so the vote window mid-1..mid+1 ends at the decision point.
  localparam logic [CW-1:0]    C_START_LAST = CW'(CLKS_PER_BIT / 2);
`else
  localparam logic [CW-1:0]    C_START_LAST = CW'(CLKS_PER_BIT / 2 - 1);
`endif

  uart_rx_state_t r_state, w_state_nxt;

  logic                      w_rxs;
  logic                      w_sample;
  logic                      w_cnt_hit;
  logic                      w_cnt_clr;
  logic                      w_shift_en;
  logic                      w_stop_ok;
  logic                      w_stop_bad;
  logic [CW-1:0]             r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_ferr;
  logic                      r_ovr;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(serial_in),
    .o_q(w_rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  logic r_h1;
  logic r_h2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h1 <= 1'b1;
      r_h2 <= 1'b1;
    end else begin
      r_h1 <= w_rxs;
      r_h2 <= r_h1;
    end
  end

  assign w_sample = maj3(r_h2, r_h1, w_rxs);
`else
  assign w_sample = w_rxs;
`endif

  assign w_cnt_hit = (r_state == START) ? (r_cnt == C_START_LAST) : (r_cnt == C_BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = START;
          w_cnt_clr   = 1'b1;
        end
      end
      START: begin
        if (w_cnt_hit) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_cnt_hit) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == C_IDX_LAST) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_cnt_hit) begin
          w_cnt_clr = 1'b1;
          if (w_sample) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must not be re-read as back-to-back start bits.
        if (w_rxs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!ena) begin
      w_state_nxt = IDLE;
      w_cnt_clr   = 1'b1;
      w_shift_en  = 1'b0;
      w_stop_ok   = 1'b0;
      w_stop_bad  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_cnt_clr || r_state == IDLE || r_state == WAIT_IDLE) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state != DATA) begin
        r_idx <= '0;
      end else if (w_shift_en) begin
        r_idx <= r_idx + 1'b1;
      end

      if (w_shift_en) r_shift[r_idx] <= w_sample;

      r_ferr <= w_stop_bad;
      r_ovr  <= w_stop_ok && r_valid && !rx_ready;

      // A consume in the same cycle frees the slot, so the new byte lands without an overrun.
      if (w_stop_ok && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit: stimulus pushes expected bytes, a negedge monitor pops and compares.
module tb_uart_rx_byte;
  import trivium_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int STOP_OFS = 155;
`else
  localparam int STOP_OFS = 154;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       serial_in = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] seq [10];
  int n_checks  = 0;
  int n_fail    = 0;
  int ferr_cnt  = 0;
  int ovr_cnt   = 0;
  int valid_run = 0;
  int last_run  = 0;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .serial_in(serial_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Monitor: flags are counted, every accepted byte is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid) begin
        valid_run++;
      end else begin
        if (valid_run != 0) last_run = valid_run;
        valid_run = 0;
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_data", {24'h0, rx_data}, {24'h0, mon_exp});
        end
      end
    end
  end

  // Inputs change 1 time unit after a rising edge; each bit lasts CPB cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    serial_in = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    serial_in = stop_b;
    repeat (CPB) @(posedge clk);
    #1;
    serial_in = 1'b1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    seq = '{8'hA5, 8'h3C, 8'h7F, 8'hC1, 8'h99, 8'h42, 8'hE7, 8'hB8, 8'h5D, 8'hF0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", {24'h0, rx_data}, 32'h0);
    check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);
    check("reset_state", 32'(dut.r_state), 32'(IDLE));
    rst = 1'b0;
    idle(20);

    // Single frame, rx_ready held high
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(20);
    drain("a5_drain");
    check("a5_valid_width", last_run, 1);
    check("a5_frame_err", ferr_cnt, 0);
    check("a5_overrun", ovr_cnt, 0);

    // Ten frames back to back
    for (int i = 0; i < 10; i++) exp_q.push_back(seq[i]);
    for (int i = 0; i < 10; i++) send_frame(seq[i], 1'b1);
    idle(30);
    drain("seq_drain");
    check("seq_frame_err", ferr_cnt, 0);
    check("seq_overrun", ovr_cnt, 0);

    // 7-cycle low glitch is rejected at the start-bit sample
    serial_in = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    idle(30);
    check("glitch_valid", {31'h0, rx_valid}, 32'h0);
    check("glitch_frame_err", ferr_cnt, 0);
    check("glitch_state", 32'(dut.r_state), 32'(IDLE));

    // Bad stop bit, then a held-low line, then a clean frame
    exp_q.push_back(8'h7F);
    send_frame(8'h3C, 1'b0);
    serial_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(CPB);
    send_frame(8'h7F, 1'b1);
    idle(20);
    drain("ferr_drain");
    check("ferr_count", ferr_cnt, 1);
    check("ferr_overrun", ovr_cnt, 0);

    // Overrun with a full buffer, then a consume coinciding with the next load
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    check("ovr_rx_data", {24'h0, rx_data}, 32'h11);
    check("ovr_rx_valid", {31'h0, rx_valid}, 32'h1);
    check("ovr_count", ovr_cnt, 1);
    exp_q.push_back(8'h33);
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (STOP_OFS) @(posedge clk);
        #1;
        rx_ready = 1'b1;
      end
    join
    idle(20);
    drain("ovr_drain");
    check("ovr_count_after", ovr_cnt, 1);

    // Reset during data bit 6 of 0xC1, then a clean 0x99
    idle(20);
    fork
      send_frame(8'hC1, 1'b1);
      begin
        repeat (118) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rx_data", {24'h0, rx_data}, 32'h0);
        check("midrst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
        check("midrst_overrun", {31'h0, overrun}, 32'h0);
        check("midrst_state", 32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;
      end
    join
    idle(20);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    idle(20);
    drain("rst_drain");
    check("rst_frame_err", ferr_cnt, 1);
    check("rst_overrun", ovr_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receive front end that deserializes 8N1 frames on `serial_in` into bytes for the Trivium cipher datapath.
- Sits directly upstream of the keystream XOR stage inside trivium_top.
- Delivers one byte per frame through a one-entry valid/ready output buffer.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per UART bit (100 MHz / 9600 baud); must be >= 4.
- SYNC_STAGES, 2, number of flops in the serial_in metastability synchronizer; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  block enable; low forces the FSM to IDLE.
- serial_in  input  1  asynchronous UART line; idle high; LSB first.
- rx_data  output  8  received byte; stable while rx_valid is high.
- rx_valid  output  1  byte available; held until consumed.
- rx_ready  input  1  downstream accepts the byte when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- overrun  output  1  one-cycle pulse when a byte is dropped because the buffer is full.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0.
  - Internals: FSM=IDLE, synchronizer flops=1, bit counter=0, baud counter=0.
  - Reset mid-frame discards the partial byte.
- serial_in passes through SYNC_STAGES flops; call the result `rxs`. All decisions use `rxs`.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when `rxs`=0 and ena=1, go to START and clear the baud counter.
- START:
  - Count to CLKS_PER_BIT/2-1 (integer division), then sample.
  - Sample 0: go to DATA with bit index 0 and clear the baud counter.
  - Sample 1: the start was a glitch; return to IDLE with no flag.
- DATA:
  - Sample each bit when the baud counter reaches CLKS_PER_BIT-1, i.e. at mid-bit.
  - Shift the sample into the shift register at bit[index], LSB first.
  - After index 7 is sampled, go to STOP.
- STOP: sample at mid-bit (counter = CLKS_PER_BIT-1).
  - Sample 1, buffer empty (or emptied this cycle): load rx_data, set rx_valid the next cycle, go to IDLE.
  - Sample 1, buffer full and not consumed this cycle: pulse overrun; keep the old rx_data/rx_valid; go to IDLE.
  - Sample 0: pulse frame_err, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: remain until `rxs`=1, then go to IDLE. This prevents a break condition from being read as repeated start bits.
- Latency: rx_valid rises 1 cycle after the stop-bit mid-sample. End-to-end from the serial_in start edge this is about SYNC_STAGES + 9.5*CLKS_PER_BIT + 1 cycles.
- Handshake:
  - rx_valid clears the cycle after rx_valid && rx_ready.
  - Simultaneous consume and new-byte load: the new byte loads, rx_valid stays 1, no overrun.
  - rx_ready while rx_valid=0 is ignored.
- ena:
  - ena=0 in any state returns the FSM to IDLE the next cycle and discards the partial frame.
  - The output buffer and handshake keep operating while ena=0.
- Baud counter width is $clog2(CLKS_PER_BIT); it never wraps past CLKS_PER_BIT-1.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every sample in START, DATA and STOP is a 2-of-3 majority vote of `rxs` at counter positions mid-1, mid and mid+1. The decision is taken at mid+1, so each frame ends 1 cycle later.
- Undefined: single sample at mid-bit, as described in Behaviour.

Decomposition:
- trivium_pkg holds the shared constants:
  - the uart_rx_state_t enum (IDLE, START, DATA, STOP, WAIT_IDLE);
  - UART_DATA_BITS=8;
  - the default CLKS_PER_BIT.
- One natural sub-module, uart_sync: the SYNC_STAGES flop chain with reset value 1, reusable by the future uart_tx loopback.
- Everything else lives in uart_rx_byte.

Test Plan (bench uses CLKS_PER_BIT=16, SYNC_STAGES=2, rx_ready=1 unless stated):
- Send frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rx_data=0xA5, rx_valid high for exactly 1 cycle, frame_err=0, overrun=0.
- Send the 10-byte sequence A5 3C 7F C1 99 42 E7 B8 5D F0 back-to-back -> the same 10 bytes appear in order, no flags.
- Hold serial_in=0 for 7 cycles, then return high -> no rx_valid, no frame_err, FSM back in IDLE.
- Send 0x3C with stop bit=0, then hold the line low 40 cycles, then send 0x7F -> one frame_err pulse, 0x3C dropped; 0x7F received correctly.
- rx_ready=0: send 0x11 then 0x22 -> rx_data stays 0x11, rx_valid=1, one overrun pulse.
  - Then raise rx_ready, send 0x33 completing in the same cycle rx_ready is asserted -> 0x33 loaded with no overrun.
- Assert rst for 1 cycle mid-way through 0xC1's data bits, then send 0x99 -> 0xC1 discarded, all outputs 0 after reset, 0x99 received.
